// File: rtl/float2fixed_pipe.sv
// float2fixed_pipe
// Streaming converter from a {sign, exponent, mantissa} float word to a
// two's-complement fixed-point word. Two register stages with valid/ready
// handshaking sustain one word per cycle. An event counter records how many
// overflowed words were delivered downstream.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous, active-high reset
//   i_in_valid   input word valid
//   o_in_ready   converter can accept a word this cycle
//   i_float_in   {sign, exp[EXP_W-1:0], mant[MANT_W-1:0]}
//   i_sat_en     1: saturate on overflow, 0: wrap; sampled with each word
//   o_out_valid  o_fixed_out / o_ovf_out valid
//   i_out_ready  downstream accepts the output word
//   o_fixed_out  two's-complement result, OUT_W bits
//   o_ovf_out    overflow flag for the output word
//   o_ovf_count  saturating count of delivered overflowed words
//   i_cnt_clear  synchronous clear of o_ovf_count (wins over an increment)
module float2fixed_pipe #(
  parameter int EXP_W   = 5,
  parameter int MANT_W  = 10,
  parameter int OUT_W   = 44,
  parameter int ZERO_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [EXP_W+MANT_W:0] i_float_in,
  input  logic                  i_sat_en,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [OUT_W-1:0]      o_fixed_out,
  output logic                  o_ovf_out,
  output logic [CNT_W-1:0]      o_ovf_count,
  input  logic                  i_cnt_clear
);

  // Largest magnitude is {1,mant} shifted by the largest exponent.
  localparam int MAG_W = MANT_W + (1 << EXP_W);
  // Comparison width holds both the magnitude and the limit without loss.
  localparam int CMP_W = ((MAG_W > OUT_W) ? MAG_W : OUT_W) + 1;
  localparam logic [CMP_W-1:0] LIM     = {{(CMP_W-1){1'b0}}, 1'b1} << (OUT_W - 1);
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] ONE_OUT = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              w_sign;
  logic [EXP_W-1:0]  w_exp;
  logic [MANT_W-1:0] w_mant;
  logic [MAG_W-1:0]  w_mag;
  logic [CMP_W-1:0]  w_mag_ext;
  logic              w_ovf;
  logic [OUT_W-1:0]  w_mag_trunc;
  logic [OUT_W-1:0]  w_result;
  logic              w_adv1;
  logic              w_adv2;

  logic              r_s1_valid;
  logic [OUT_W-1:0]  r_s1_mag;
  logic              r_s1_sign;
  logic              r_s1_ovf;
  logic              r_s1_sat;
  logic              r_out_valid;
  logic [OUT_W-1:0]  r_fixed;
  logic              r_ovf_out;
  logic [CNT_W-1:0]  r_cnt;

  assign w_sign = i_float_in[EXP_W+MANT_W];
  assign w_exp  = i_float_in[EXP_W+MANT_W-1:MANT_W];
  assign w_mant = i_float_in[MANT_W-1:0];

  // Stage 2 may load when it is empty or its word leaves this cycle;
  // stage 1 may load when it is empty or can hand its word to stage 2.
  assign w_adv2     = ~r_out_valid | i_out_ready;
  assign w_adv1     = ~r_s1_valid | w_adv2;
  assign o_in_ready = w_adv1 | i_reset;

  // Decode the incoming word into its full-width magnitude and overflow flag.
  always_comb begin
    if ((ZERO_EN != 0) && (w_exp == {EXP_W{1'b0}}) && (w_mant == {MANT_W{1'b0}})) begin
      w_mag = {MAG_W{1'b0}};
    end else begin
      w_mag = {{(MAG_W-MANT_W-1){1'b0}}, 1'b1, w_mant} << w_exp;
    end
    w_mag_ext = {{(CMP_W-MAG_W){1'b0}}, w_mag};
    // A negative result may reach exactly -LIM; a positive one stops at LIM-1.
    if (w_sign) begin
      w_ovf = (w_mag_ext > LIM);
    end else begin
      w_ovf = (w_mag_ext >= LIM);
    end
    // Only the low OUT_W bits are needed once overflow is known.
    w_mag_trunc = w_mag_ext[OUT_W-1:0];
  end

  // Form the output word from the stage-1 magnitude, sign and mode.
  always_comb begin
    if (r_s1_ovf && r_s1_sat) begin
      if (r_s1_sign) begin
        w_result = SAT_NEG;
      end else begin
        w_result = SAT_POS;
      end
    end else if (r_s1_sign) begin
      // Wrap and in-range negative results share the truncated negation.
      w_result = (~r_s1_mag) + ONE_OUT;
    end else begin
      w_result = r_s1_mag;
    end
  end

  // Stage 1: capture the decoded word when the stage is free to move.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mag   <= {OUT_W{1'b0}};
      r_s1_sign  <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_sat   <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1_mag  <= w_mag_trunc;
        r_s1_sign <= w_sign;
        r_s1_ovf  <= w_ovf;
        r_s1_sat  <= i_sat_en;
      end
    end
  end

  // Stage 2: registered outputs, held stable while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_fixed     <= {OUT_W{1'b0}};
      r_ovf_out   <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_fixed   <= w_result;
        r_ovf_out <= r_s1_ovf;
      end
    end
  end

  // Saturating count of overflowed words actually handed downstream.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_cnt_clear) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_out_valid && i_out_ready && r_ovf_out && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_fixed_out = r_fixed;
  assign o_ovf_out   = r_ovf_out;
  assign o_ovf_count = r_cnt;

endmodule

// File: doc/float2fixed_pipe.md
Name: float2fixed_pipe

Overview:
Parametrised, streaming successor to the single-cycle float2fixed converter. Converts a sign/exponent/mantissa float word to a two's-complement fixed word with configurable field widths, output width, zero-encoding and saturate/wrap overflow handling. Sits between float producers and fixed-point datapaths. Uses a 2-stage valid/ready pipeline with full throughput and a saturating overflow event counter.

Parameters:
EXP_W, 5, exponent field width (bits)
MANT_W, 10, mantissa field width (bits)
OUT_W, 44, fixed output width (bits, two's complement)
ZERO_EN, 1, 1: input with exp==0 and mant==0 converts to 0; 0: legacy hidden-bit mapping (gives 1<<MANT_W)
CNT_W, 16, overflow counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  converter can accept input this cycle
float_in  in  1+EXP_W+MANT_W  {sign, exp, mant}
sat_en  in  1  1: saturate on overflow; 0: wrap (truncate); sampled with each accepted word
out_valid  out  1  fixed_out valid
out_ready  in  1  downstream accepts fixed_out
fixed_out  out  OUT_W  two's-complement result
ovf_out  out  1  overflow flag, qualified by out_valid
ovf_count  out  CNT_W  number of overflowed words delivered, saturating
cnt_clear  in  1  synchronous clear of ovf_count

Behaviour:
- Reset (synchronous, active-high): out_valid=0, fixed_out=0, ovf_out=0, ovf_count=0, both stage valids=0. A word in flight at reset is discarded; nothing is emitted.
- in_ready is high during reset and continues to follow the stall rule below.
- Arithmetic, with MAG_W = MANT_W + 2^EXP_W:
  - mag = {1'b1, mant} << exp, computed at MAG_W bits, never truncated internally.
  - If ZERO_EN and exp==0 and mant==0: mag = 0.
- Overflow, with LIM = 2^(OUT_W-1):
  - sign=0: ovf = (mag >= LIM).
  - sign=1: ovf = (mag > LIM).
  - With defaults (OUT_W=44, max mag is 42 bits), ovf is never asserted.
- Result:
  - No ovf: fixed_out = sign ? -mag : mag, taken at OUT_W bits.
  - ovf and sat_en=1: fixed_out = LIM-1 when sign=0, -LIM when sign=1.
  - ovf and sat_en=0: fixed_out = sign ? -(mag[OUT_W-1:0]) : mag[OUT_W-1:0].
  - ovf_out = ovf in both modes.
- Pipeline stages:
  - Stage 1 registers the decoded mag, sign, ovf and sat_en.
  - Stage 2 registers fixed_out and ovf_out, and drives out_valid.
- Latency: 2 cycles from the accepting edge (in_valid & in_ready) to out_valid, when not stalled.
- Throughput: one word per cycle.
- Handshake:
  - adv2 = ~out_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1 (combinational from out_ready; no skid buffer).
  - On adv2: out_valid <= s1_valid. Data updates only when s1_valid is 1; held otherwise.
  - On adv1: s1_valid <= in_valid & in_ready.
  - While out_valid & ~out_ready: fixed_out and ovf_out hold stable.
  - No loss, duplication or reordering of words.
- ovf_count:
  - Increments by 1 on each output transfer (out_valid & out_ready) with ovf_out=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clear has priority over a simultaneous increment; the result is 0.
- sat_en and ZERO_EN affect only the word sampled with them; a mode change mid-stream does not alter words already in flight.

Test Plan:
- Defaults, float_in=16'h3C00 -> 2 cycles later fixed_out=44'h000_0200_0000, ovf_out=0. float_in=16'hBC00 -> 44'hFFF_FE00_0000.
- float_in=16'h0000: with ZERO_EN=1 -> fixed_out=0; with ZERO_EN=0 -> 44'h000_0000_0400. float_in=16'h7FFF -> 44'h3FF_8000_0000.
- OUT_W=32, sat_en=1:
  - 16'h7FFF -> 32'h7FFF_FFFF, ovf_out=1, ovf_count 0->1.
  - 16'hFFFF -> 32'h8000_0000.
  - sat_en=0 with 16'h7FFF -> 32'h8000_0000, ovf_out=1.
- Backpressure: stream A,B,C,D with in_valid=1 and out_ready=0 from cycle 0:
  - A and B are accepted, then in_ready=0 and fixed_out holds A.
  - After out_ready=1: outputs are A,B,C,D in order, one per cycle, no duplicates.
- Counter: CNT_W=2 with 5 overflowing transfers -> ovf_count saturates at 3. cnt_clear asserted in the same cycle as an overflow transfer -> ovf_count=0.
- Reset asserted for 1 cycle with 2 words in flight -> next cycle out_valid=0, fixed_out=0, ovf_count=0. The first word accepted after reset appears 2 cycles later.
- Random: a 10k-word random stream with random out_ready is compared against the arithmetic model above, with zero mismatches.
